// File: rtl/fp_pkg.sv
// Shared parameters, payload types and ring-pointer helper for the fingerprint hasher.
package fp_pkg;

    localparam int unsigned PEAKS          = 6;
    localparam int unsigned FREQ_WIDTH     = 8;
    localparam int unsigned AMPL_WIDTH     = 16;
    localparam int unsigned TIME_WIDTH     = 16;
    localparam int unsigned TARGET_FRAMES  = 3;
    localparam int unsigned DT_WIDTH       = $clog2(TARGET_FRAMES + 1);
    localparam int unsigned DEPTH          = TARGET_FRAMES + 1;
    localparam int unsigned PTR_WIDTH      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_WIDTH      = $clog2(DEPTH + 1);
    localparam int unsigned PEAK_IDX_WIDTH = (PEAKS > 1) ? $clog2(PEAKS) : 1;
    localparam int unsigned HASH_WIDTH     = 2 * FREQ_WIDTH + DT_WIDTH;
    localparam int unsigned DROP_WIDTH     = 8;

    typedef logic [PEAKS-1:0][FREQ_WIDTH-1:0] freq_vec_t;
    typedef logic [PEAKS-1:0][AMPL_WIDTH-1:0] amp_vec_t;

    // One frame of peaks; "time" is a keyword, hence frame_time.
    typedef struct packed {
        freq_vec_t               freqs;
        amp_vec_t                amps;
        logic [TIME_WIDTH-1:0]   frame_time;
    } peak_frame_t;

    typedef struct packed {
        logic [FREQ_WIDTH-1:0]   f_anchor;
        logic [FREQ_WIDTH-1:0]   f_target;
        logic [DT_WIDTH-1:0]     dt;
    } fp_hash_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        POP  = 2'd2
    } fsm_state_t;

    // Ring pointer addition modulo DEPTH (off is always below DEPTH).
    function automatic logic [PTR_WIDTH-1:0] ptr_add(input logic [PTR_WIDTH-1:0] ptr,
                                                     input logic [PTR_WIDTH-1:0] off);
        logic [PTR_WIDTH:0] sum;
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PTR_WIDTH + 1)'(DEPTH)) begin
            sum = sum - (PTR_WIDTH + 1)'(DEPTH);
        end
        return sum[PTR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/fingerprint_hasher_if.sv
// Peak-frame intake and hash output handshake bundle.
interface fingerprint_hasher_if;
    import fp_pkg::*;

    logic                   peaks_valid;
    logic                   peaks_ready;
    freq_vec_t              freqs_in;
    amp_vec_t               amps_in;
    logic [TIME_WIDTH-1:0]  time_in;
    fp_hash_t               hash_out;
    logic [TIME_WIDTH-1:0]  anchor_time_out;
    logic                   hash_valid;
    logic                   hash_ready;

    modport master (
        output peaks_valid, freqs_in, amps_in, time_in, hash_ready,
        input  peaks_ready, hash_out, anchor_time_out, hash_valid
    );

    modport slave (
        input  peaks_valid, freqs_in, amps_in, time_in, hash_ready,
        output peaks_ready, hash_out, anchor_time_out, hash_valid
    );

endinterface

// File: rtl/fingerprint_hasher_buffer.sv
// Ring of the most recent DEPTH peak frames with anchor and target read ports.
module peak_frame_buffer
    import fp_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  peak_frame_t           push_frame,
    input  logic                  pop,
    input  logic [PTR_WIDTH-1:0]  target_off,
    output peak_frame_t           anchor_frame,
    output freq_vec_t             target_freqs,
    output amp_vec_t              target_amps,
    output logic [CNT_WIDTH-1:0]  count
);

    peak_frame_t           mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  target_ptr;

    // Frame storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_frame;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_add(wr_ptr, PTR_WIDTH'(1));
            end
            if (pop) begin
                rd_ptr <= ptr_add(rd_ptr, PTR_WIDTH'(1));
            end
            if (push && !pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (pop && !push) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    assign target_ptr   = ptr_add(rd_ptr, target_off);
    assign anchor_frame = mem[rd_ptr];
    assign target_freqs = mem[target_ptr].freqs;
    assign target_amps  = mem[target_ptr].amps;

endmodule

// File: rtl/fingerprint_hasher.sv
// Pairs anchor-frame peaks with target-zone peaks and streams constellation hashes.
module fingerprint_hasher
    import fp_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    fingerprint_hasher_if.slave    bus,
    output logic [DROP_WIDTH-1:0]  drop_count
);

    localparam logic [PEAK_IDX_WIDTH-1:0] LAST_PEAK = PEAK_IDX_WIDTH'(PEAKS - 1);
    localparam logic [DT_WIDTH-1:0]       LAST_DT   = DT_WIDTH'(TARGET_FRAMES);

    fsm_state_t                 state;
    logic [PEAK_IDX_WIDTH-1:0]  a_idx;
    logic [PEAK_IDX_WIDTH-1:0]  t_idx;
    logic [DT_WIDTH-1:0]        d_idx;
    fp_hash_t                   hash_q;
    logic [TIME_WIDTH-1:0]      anchor_time_q;
    logic                       hash_valid_q;
    logic                       peaks_ready_q;
    logic [DROP_WIDTH-1:0]      drop_q;

    peak_frame_t                push_frame_c;
    peak_frame_t                anchor_frame;
    freq_vec_t                  target_freqs;
    amp_vec_t                   target_amps;
    logic [CNT_WIDTH-1:0]       count;
    logic                       push_c;
    logic                       pop_c;
    logic                       slot_free_c;
    logic                       cand_valid_c;
    logic                       last_cand_c;

    // Candidate evaluation and buffer control.
    assign push_frame_c = '{freqs: bus.freqs_in, amps: bus.amps_in, frame_time: bus.time_in};
    assign push_c       = (state == IDLE) && bus.peaks_valid;
    assign pop_c        = (state == POP);
    assign slot_free_c  = !hash_valid_q || bus.hash_ready;
    assign cand_valid_c = (anchor_frame.amps[a_idx] != '0) && (target_amps[t_idx] != '0);
    assign last_cand_c  = (a_idx == LAST_PEAK) && (d_idx == LAST_DT) && (t_idx == LAST_PEAK);

    peak_frame_buffer u_buffer (
        .clk          (clk),
        .reset        (reset),
        .push         (push_c),
        .push_frame   (push_frame_c),
        .pop          (pop_c),
        .target_off   (PTR_WIDTH'(d_idx)),
        .anchor_frame (anchor_frame),
        .target_freqs (target_freqs),
        .target_amps  (target_amps),
        .count        (count)
    );

    // Control FSM with registered handshake outputs and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            a_idx         <= '0;
            d_idx         <= '0;
            t_idx         <= '0;
            hash_q        <= '0;
            anchor_time_q <= '0;
            hash_valid_q  <= 1'b0;
            peaks_ready_q <= 1'b1;
            drop_q        <= '0;
        end else begin
            if (bus.peaks_valid && !peaks_ready_q && (drop_q != '1)) begin
                drop_q <= drop_q + DROP_WIDTH'(1);
            end
            if (hash_valid_q && bus.hash_ready) begin
                hash_valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (bus.peaks_valid && (count == CNT_WIDTH'(DEPTH - 1))) begin
                        state         <= GEN;
                        peaks_ready_q <= 1'b0;
                        a_idx         <= '0;
                        d_idx         <= DT_WIDTH'(1);
                        t_idx         <= '0;
                    end
                end
                GEN: begin
                    if (slot_free_c) begin
                        if (cand_valid_c) begin
                            hash_q        <= '{f_anchor: anchor_frame.freqs[a_idx],
                                               f_target: target_freqs[t_idx],
                                               dt:       d_idx};
                            anchor_time_q <= anchor_frame.frame_time;
                            hash_valid_q  <= 1'b1;
                        end
                        if (last_cand_c) begin
                            state <= POP;
                        end else if (t_idx != LAST_PEAK) begin
                            t_idx <= t_idx + PEAK_IDX_WIDTH'(1);
                        end else begin
                            t_idx <= '0;
                            if (d_idx != LAST_DT) begin
                                d_idx <= d_idx + DT_WIDTH'(1);
                            end else begin
                                d_idx <= DT_WIDTH'(1);
                                a_idx <= a_idx + PEAK_IDX_WIDTH'(1);
                            end
                        end
                    end
                end
                POP: begin
                    state         <= IDLE;
                    peaks_ready_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.peaks_ready     = peaks_ready_q;
    assign bus.hash_out        = hash_q;
    assign bus.anchor_time_out = anchor_time_q;
    assign bus.hash_valid      = hash_valid_q;
    assign drop_count          = drop_q;

endmodule

// File: tb/tb_fingerprint_hasher.sv
// Randomized bench for fingerprint_hasher against a sliding-window hash model.
module tb_fingerprint_hasher;

    localparam int NP = 6;
    localparam int NT = 3;
    localparam int FW = 8;
    localparam int DW = 2;
    localparam int TW = 16;
    localparam int HW = 2 * FW + DW;

    typedef struct packed {
        logic [FW-1:0] fa;
        logic [FW-1:0] ft;
        logic [DW-1:0] dt;
        logic [TW-1:0] tm;
    } tb_hash_t;

    typedef struct {
        int unsigned f[NP];
        int unsigned a[NP];
        int unsigned tm;
    } tb_frame_t;

    logic       clk;
    logic       reset;
    logic [7:0] drop_count;

    fingerprint_hasher_if bus();

    fingerprint_hasher dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drop_count (drop_count)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ready_mode = 0;
    int stall_viol = 0;
    logic prev_stall = 1'b0;
    tb_hash_t prev_h;
    tb_hash_t mon_h;
    tb_frame_t hist[$];
    tb_hash_t exp_q[$];
    tb_hash_t got_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.hash_ready = 1'b1;
            1:       bus.hash_ready = (cyc % 3 == 0);
            2:       bus.hash_ready = 1'($urandom_range(0, 1));
            default: bus.hash_ready = 1'b0;
        endcase
    end

    function automatic tb_hash_t sample_hash();
        logic [HW-1:0] raw;
        tb_hash_t h;
        raw  = bus.hash_out;
        h.fa = raw[HW-1 -: FW];
        h.ft = raw[HW-FW-1 -: FW];
        h.dt = raw[DW-1:0];
        h.tm = bus.anchor_time_out;
        return h;
    endfunction

    // Collect transferred hashes and watch stalled outputs for stability.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            mon_h = sample_hash();
            if (prev_stall && (bus.hash_valid !== 1'b1 || mon_h !== prev_h)) stall_viol++;
            if (bus.hash_valid === 1'b1 && bus.hash_ready === 1'b1) got_q.push_back(mon_h);
            prev_stall = (bus.hash_valid === 1'b1) && (bus.hash_ready === 1'b0);
            prev_h = mon_h;
        end
    end

    // Sliding window: once NT+1 frames are held, pair the oldest with all followers.
    function automatic void model_push(input tb_frame_t fr);
        tb_hash_t h;
        hist.push_back(fr);
        if (hist.size() == NT + 1) begin
            for (int a = 0; a < NP; a++)
                for (int d = 1; d <= NT; d++)
                    for (int t = 0; t < NP; t++)
                        if (hist[0].a[a] != 0 && hist[d].a[t] != 0) begin
                            h.fa = FW'(hist[0].f[a]);
                            h.ft = FW'(hist[d].f[t]);
                            h.dt = DW'(d);
                            h.tm = TW'(hist[0].tm);
                            exp_q.push_back(h);
                        end
            void'(hist.pop_front());
        end
    endfunction

    function automatic tb_frame_t seq_frame(input int idx, input logic [NP-1:0] mask);
        tb_frame_t fr;
        for (int k = 0; k < NP; k++) begin
            fr.f[k] = 10 * idx + k;
            fr.a[k] = mask[k] ? 1 : 0;
        end
        fr.tm = idx;
        return fr;
    endfunction

    function automatic tb_frame_t rand_frame(input int unsigned tm, input int zero_pct);
        tb_frame_t fr;
        for (int k = 0; k < NP; k++) begin
            fr.f[k] = $urandom_range(0, 255);
            fr.a[k] = ($urandom_range(0, 99) < zero_pct) ? 0 : $urandom_range(1, 65535);
        end
        fr.tm = tm;
        return fr;
    endfunction

    task automatic drive_frame(input tb_frame_t fr);
        for (int k = 0; k < NP; k++) begin
            bus.freqs_in[k] = FW'(fr.f[k]);
            bus.amps_in[k]  = 16'(fr.a[k]);
        end
        bus.time_in = TW'(fr.tm);
    endtask

    task automatic send_frame(input tb_frame_t fr);
        int guard = 0;
        @(posedge clk); #1;
        while (bus.peaks_ready !== 1'b1 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: peaks_ready=%b after %0d cycles, want 1", bus.peaks_ready, guard);
        end
        drive_frame(fr);
        bus.peaks_valid = 1'b1;
        @(posedge clk); #1;
        bus.peaks_valid = 1'b0;
        model_push(fr);
    endtask

    task automatic offer_junk(input int n_cycles);
        @(posedge clk); #1;
        drive_frame(rand_frame($urandom_range(0, 65535), 0));
        bus.peaks_valid = 1'b1;
        repeat (n_cycles) @(posedge clk);
        #1;
        bus.peaks_valid = 1'b0;
    endtask

    task automatic wait_hashes(input int n, input int budget);
        int c = 0;
        while (got_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.peaks_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
        exp_q.delete();
        got_q.delete();
        stall_viol = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.hash_valid !== 1'b0) begin failures++; $display("FAIL reset_hash_valid: got %b want 0", bus.hash_valid); end
        checks++; if (bus.hash_out !== '0) begin failures++; $display("FAIL reset_hash_out: got %h want 0", bus.hash_out); end
        checks++; if (bus.anchor_time_out !== '0) begin failures++; $display("FAIL reset_anchor_time: got %h want 0", bus.anchor_time_out); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        checks++; if (bus.peaks_ready !== 1'b1) begin failures++; $display("FAIL reset_peaks_ready: got %b want 1", bus.peaks_ready); end
    endtask

    task automatic test_basic();
        int low = -1;
        int first_valid = -1;
        tb_hash_t want;
        ready_mode = 0;
        for (int i = 0; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (first_valid < 0 && bus.hash_valid === 1'b1) first_valid = k;
            if (bus.peaks_ready === 1'b1) begin
                low = k;
                break;
            end
        end
        checks++; if (low != 109) begin failures++; $display("FAIL basic_ready_low: got %0d cycles want 109", low); end
        checks++; if (first_valid != 1) begin failures++; $display("FAIL basic_first_latency: got %0d want 1", first_valid); end
        wait_hashes(108, 300);
        checks++; if (got_q.size() != 108) begin failures++; $display("FAIL basic_count: got %0d want 108", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        want = {8'd0, 8'd10, 2'd1, 16'd0};
        checks++; if (got_q.size() == 0 || got_q[0] !== want) begin failures++; $display("FAIL basic_first_hash: got %h want %h", (got_q.size() > 0) ? got_q[0] : '0, want); end
        want = {8'd5, 8'd35, 2'd3, 16'd0};
        checks++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== want) begin failures++; $display("FAIL basic_last_hash: got %h want %h", (got_q.size() > 0) ? got_q[got_q.size()-1] : '0, want); end
    endtask

    task automatic test_slide();
        int bad_time = 0;
        got_q.delete();
        exp_q.delete();
        send_frame(rand_frame(4, 25));
        wait_hashes(exp_q.size(), 400);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL slide_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL slide_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        foreach (got_q[i]) if (got_q[i].tm != 16'd1) bad_time++;
        checks++; if (bad_time != 0) begin failures++; $display("FAIL slide_anchor_time: %0d hashes with anchor time other than 1", bad_time); end
    endtask

    task automatic test_sparse_anchor();
        int bad_anchor = 0;
        do_reset();
        send_frame(seq_frame(0, 6'b000100));
        for (int i = 1; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        wait_hashes(18, 300);
        checks++; if (got_q.size() != 18) begin failures++; $display("FAIL sparse_count: got %0d want 18", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL sparse_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        foreach (got_q[i]) if (got_q[i].fa != 8'd2) bad_anchor++;
        checks++; if (bad_anchor != 0) begin failures++; $display("FAIL sparse_anchor_freq: %0d hashes with f_anchor other than 2", bad_anchor); end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready_mode = 1;
        for (int i = 0; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        wait_hashes(108, 1200);
        ready_mode = 0;
        checks++; if (got_q.size() != 108) begin failures++; $display("FAIL bp_count: got %0d want 108", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_viol); end
    endtask

    task automatic test_drop();
        do_reset();
        ready_mode = 0;
        for (int i = 0; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        for (int p = 0; p < 5; p++) begin
            offer_junk(1);
            repeat (3) @(posedge clk);
        end
        wait_hashes(108, 300);
        checks++; if (drop_count !== 8'd5) begin failures++; $display("FAIL drop_count5: got %0d want 5", drop_count); end
        checks++; if (got_q.size() != 108) begin failures++; $display("FAIL drop_stream_count: got %0d want 108", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL drop_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        // Saturation: stall the consumer so intake stays closed, then flood.
        do_reset();
        ready_mode = 3;
        for (int i = 0; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        offer_junk(300);
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL drop_stalled_count: got %0d want 0", got_q.size()); end
        ready_mode = 0;
        wait_hashes(108, 300);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL drop_release_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL drop_hold: got %0d want 255", drop_count); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL drop_stall_stable: got %0d unstable stalls want 0", stall_viol); end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        ready_mode = 0;
        for (int i = 0; i <= NT; i++) send_frame(seq_frame(i, 6'h3F));
        while (got_q.size() < 40 && c < 300) begin
            @(negedge clk);
            c++;
        end
        checks++; if (got_q.size() < 40) begin failures++; $display("FAIL midrst_reach40: got %0d hashes want 40", got_q.size()); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.hash_valid !== 1'b0) begin failures++; $display("FAIL midrst_hash_valid: got %b want 0", bus.hash_valid); end
        checks++; if (bus.peaks_ready !== 1'b1) begin failures++; $display("FAIL midrst_peaks_ready: got %b want 1", bus.peaks_ready); end
        checks++; if (bus.hash_out !== '0) begin failures++; $display("FAIL midrst_hash_out: got %h want 0", bus.hash_out); end
        do_reset();
        for (int i = 0; i < NT; i++) send_frame(rand_frame(i, 0));
        repeat (150) @(negedge clk);
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_no_hashes: got %0d want %0d", got_q.size(), exp_q.size()); end
        checks++; if (bus.peaks_ready !== 1'b1) begin failures++; $display("FAIL midrst_still_idle: got %b want 1", bus.peaks_ready); end
    endtask

    task automatic test_random();
        do_reset();
        ready_mode = 2;
        for (int i = 0; i < 7; i++) send_frame(rand_frame(100 + 3 * i, 30));
        wait_hashes(exp_q.size(), 2000);
        ready_mode = 0;
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_hash[%0d]: got %0d/%0d/%0d t%0d want %0d/%0d/%0d t%0d", i,
                         got_q[i].fa, got_q[i].ft, got_q[i].dt, got_q[i].tm, exp_q[i].fa, exp_q[i].ft, exp_q[i].dt, exp_q[i].tm);
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL rand_stall_stable: got %0d unstable stalls want 0", stall_viol); end
    endtask

    initial begin
        reset = 1'b1;
        bus.peaks_valid = 1'b0;
        bus.freqs_in = '0;
        bus.amps_in = '0;
        bus.time_in = '0;
        test_reset();
        test_basic();
        test_slide();
        test_sparse_anchor();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
